ibex_instr_mem_responder: RTL and testbench
===========================================

Name: ibex_instr_mem_responder

Overview:
- Responder (memory) end of the Ibex instruction-fetch bus (req/gnt/rvalid) that feeds the core's fetch FIFO.
- Grants fetch requests after programmable wait states and reads a word-addressed synchronous instruction SRAM.
- Returns rdata/err in order after a programmable response latency, with a bounded number of outstanding transactions.
- Sits between the core's instruction port and the on-chip instruction SRAM macro.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window.
- MEM_AW, 10, SRAM word-address width; window size is 4*2^MEM_AW bytes.
- WAIT_STATES, 0, idle cycles of req before gnt (0..15).
- RESP_LATENCY, 1, cycles from gnt to rvalid (1..4).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (1..RESP_LATENCY+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  byte address; bits [1:0] ignored
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid, one-cycle pulse, no backpressure
- instr_rdata_o  out  32  response data
- instr_err_o  out  1  bus error for this response
- mem_en_o  out  1  SRAM read enable
- mem_addr_o  out  MEM_AW  SRAM word address
- mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_en_o

Behaviour:
- Reset (async, rst_ni low): gnt=0, rvalid=0, rdata=0, err=0, mem_en=0, wait counter=0, outstanding=0, response pipeline empty. Reset mid-transaction discards all in-flight responses; no rvalid is issued for them after release.
- Wait counter: increments each cycle req=1 and gnt=0. Cleared on gnt and whenever req=0. Eligible when count==WAIT_STATES; with WAIT_STATES=0, gnt is combinational in the cycle req rises.
- gnt = req & eligible & (outstanding < MAX_OUTSTANDING | rvalid_this_cycle). A retiring response frees its slot in the same cycle.
- In-range check: BASE_ADDR <= addr < BASE_ADDR + 4*2^MEM_AW, computed in 33-bit arithmetic so the window may end at 2^32 without wrap.
- Granted, in range: mem_en=1 and mem_addr=(addr-BASE_ADDR)>>2 in the gnt cycle; response err=0, data=mem_rdata_i.
- Granted, out of range: mem_en=0; response err=1, rdata=0.
- mem_en=0 in every non-gnt cycle.
- Response pipeline: valid/err flag shift register of RESP_LATENCY stages. SRAM data is captured into the pipeline at stage 1; later stages are registered.
- rvalid is asserted exactly RESP_LATENCY cycles after the corresponding gnt. Responses are strictly in order, and one response is possible every cycle.
- Outstanding counter: +1 on gnt, -1 on rvalid, unchanged when both occur. Never exceeds MAX_OUTSTANDING and never underflows.
- If req drops after gnt, already-granted responses are still delivered. The protocol has no cancel; the core discards unwanted data.
- instr_addr_i is sampled only in the gnt cycle; changes while gnt=0 are legal.

Optional Feature:
- Macro IBEX_INSTR_RESP_STALL_INJECT_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, reset to seed, advances every cycle) masks gnt when its bit 0 is 1. This adds random extra wait states for fetch-FIFO stress testing; all ordering, latency and outstanding rules still hold.
- Undefined: no LFSR logic; gnt timing is exactly as above.

Decomposition:
- Shared package ibex_instr_mem_pkg:
  - response-stage struct {valid, err, rdata[31:0]}
  - localparam MAX_RESP_LATENCY=4
  - LFSR seed and tap constants
- One natural sub-module: ibex_instr_resp_pipe, the parameterised RESP_LATENCY delay line of response stages with async reset.

Test Plan:
- Single fetch, defaults, addr 32'h0000_0010, SRAM word 4 = 32'hDEAD_BEEF → gnt the same cycle, mem_addr=4, rvalid 1 cycle later with rdata=DEAD_BEEF, err=0.
- Back-to-back req held high over addrs 0,4,8,C with MAX_OUTSTANDING=2, RESP_LATENCY=1 → gnt every cycle, four in-order rvalids on consecutive cycles, outstanding never >2.
- RESP_LATENCY=3, MAX_OUTSTANDING=2, req held → gnt on cycles 0 and 1, gnt low on cycle 2 (limit reached), gnt on cycle 3 coincident with the first rvalid.
- WAIT_STATES=2 → gnt on the third cycle of req; req dropped after 1 cycle then reasserted → counter restarts and gnt comes 2 cycles after reassertion.
- Addr BASE_ADDR+4*2^MEM_AW, and addr 32'hFFFF_FFFC with BASE_ADDR=32'hFFFF_F000, MEM_AW=10 → first gives err=1, rdata=0, mem_en=0; second is in range, err=0.
- rst_ni pulsed low while 2 responses are outstanding → no rvalid after release, all outputs 0, the next request serviced normally.

Source files
------------

// File: rtl/ibex_instr_mem_pkg.sv
// Shared types and constants for the Ibex instruction-fetch memory responder.
package ibex_instr_mem_pkg;

    localparam int MAX_RESP_LATENCY = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

endpackage

// File: rtl/ibex_instr_mem_responder_if.sv
// Ibex instruction-fetch bus (req/gnt/rvalid) between core and responder.
interface ibex_instr_mem_responder_if;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err
    );

endinterface

// File: rtl/ibex_instr_resp_pipe.sv
// In-order response delay line; SRAM read data joins the stream at stage 1.
module ibex_instr_resp_pipe
    import ibex_instr_mem_pkg::*;
#(
    parameter int RESP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_valid,
    input  logic        i_err,
    input  logic [31:0] i_mem_rdata,
    output resp_t       o_resp
);

    logic  r_valid0;
    logic  r_err0;
    resp_t w_head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid0 <= 1'b0;
            r_err0   <= 1'b0;
        end else begin
            r_valid0 <= i_valid;
            r_err0   <= i_err;
        end
    end

    // Data is forced to zero on errors and idle slots
    always_comb begin
        w_head.valid = r_valid0;
        w_head.err   = r_err0;
        w_head.rdata = (r_valid0 && !r_err0) ? i_mem_rdata : '0;
    end

    if (RESP_LATENCY == 1) begin : g_short
        assign o_resp = w_head;
    end else begin : g_long
        resp_t r_stg [1:RESP_LATENCY-1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 1; i < RESP_LATENCY; i++) begin
                    r_stg[i] <= '0;
                end
            end else begin
                r_stg[1] <= w_head;
                for (int i = 2; i < RESP_LATENCY; i++) begin
                    r_stg[i] <= r_stg[i-1];
                end
            end
        end

        assign o_resp = r_stg[RESP_LATENCY-1];
    end

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Memory-side responder for the Ibex fetch bus over a synchronous SRAM.
// Define IBEX_INSTR_RESP_STALL_INJECT_EN to add LFSR-driven random grant stalls.
module ibex_instr_mem_responder
    import ibex_instr_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          MEM_AW          = 10,
    parameter int          WAIT_STATES     = 0,
    parameter int          RESP_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ibex_instr_mem_responder_if.slave  bus,
    output logic                       mem_en_o,
    output logic [MEM_AW-1:0]          mem_addr_o,
    input  logic [31:0]                mem_rdata_i
);

    localparam int          OW      = $clog2(MAX_RESP_LATENCY + 2);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    // 33-bit window bounds so a window ending at 2^32 does not wrap
    localparam logic [32:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI  = WIN_LO + (33'd4 << MEM_AW);

    logic [3:0]        r_wait_cnt;
    logic [OW-1:0]     r_outst;
    logic              w_eligible;
    logic              w_slot;
    logic              w_stall;
    logic              w_gnt;
    logic              w_in_range;
    logic [MEM_AW-1:0] w_word;
    resp_t             w_resp;

    assign w_in_range = ({1'b0, bus.instr_addr} >= WIN_LO) &&
                        ({1'b0, bus.instr_addr} <  WIN_HI);
    assign w_word     = MEM_AW'((bus.instr_addr - BASE_ADDR) >> 2);
    assign w_eligible = (r_wait_cnt == WS);
    // A response retiring this cycle frees its slot immediately
    assign w_slot     = (r_outst < MAX_OUT) || w_resp.valid;
    assign w_gnt      = rst_ni && bus.instr_req && w_eligible &&
                        w_slot && !w_stall;

`ifdef IBEX_INSTR_RESP_STALL_INJECT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end

    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    // Saturates at WS so a slot-limited request stays eligible
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if (!bus.instr_req || w_gnt) begin
            r_wait_cnt <= '0;
        end else if (!w_eligible) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outst <= '0;
        end else begin
            case ({w_gnt, w_resp.valid})
                2'b10:   r_outst <= r_outst + OW'(1);
                2'b01:   r_outst <= r_outst - OW'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    ibex_instr_resp_pipe #(
        .RESP_LATENCY (RESP_LATENCY)
    ) u_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_valid     (w_gnt),
        .i_err       (w_gnt && !w_in_range),
        .i_mem_rdata (mem_rdata_i),
        .o_resp      (w_resp)
    );

    assign bus.instr_gnt    = w_gnt;
    assign bus.instr_rvalid = w_resp.valid;
    assign bus.instr_rdata  = w_resp.rdata;
    assign bus.instr_err    = w_resp.err;
    assign mem_en_o         = w_gnt && w_in_range;
    assign mem_addr_o       = w_word;

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Four responder configurations driven by directed fetch vectors;
// per-instance monitors pop the expected-response queues on rvalid.
`timescale 1ns/1ps
module tb_ibex_instr_mem_responder;

    localparam int N = 4;
    localparam logic [31:0] BA  [N] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_F000};
    localparam int          LAT [N] = '{1, 3, 1, 1};
    localparam int          WSN [N] = '{0, 0, 2, 0};

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q [N][$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [N-1:0] req  = '0;
    logic [N-1:0] gnt, rvalid, err, en;
    logic [31:0] addr  [N];
    logic [31:0] rdata [N];
    logic [9:0]  maddr [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdl(input logic [9:0] w);
        return (w == 10'd4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {22'd0, w});
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    for (genvar K = 0; K < N; K++) begin : g_dut
        ibex_instr_mem_responder_if bus ();
        logic [31:0] mrd;
        logic [9:0]  ma;
        logic        me;

        assign bus.instr_req  = req[K];
        assign bus.instr_addr = addr[K];
        assign gnt[K]    = bus.instr_gnt;
        assign rvalid[K] = bus.instr_rvalid;
        assign err[K]    = bus.instr_err;
        assign rdata[K]  = bus.instr_rdata;
        assign en[K]     = me;
        assign maddr[K]  = ma;

        ibex_instr_mem_responder #(
            .BASE_ADDR       (BA[K]),
            .MEM_AW          (10),
            .WAIT_STATES     (WSN[K]),
            .RESP_LATENCY    (LAT[K]),
            .MAX_OUTSTANDING (2)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .bus         (bus),
            .mem_en_o    (me),
            .mem_addr_o  (ma),
            .mem_rdata_i (mrd)
        );

        always @(posedge clk) if (me) mrd <= mdl(ma);

        always @(negedge clk) begin : mon
            exp_t e;
            if (rvalid[K]) begin
                if (q[K].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid dut%0d cyc%0d: got rvalid=1 want none",
                             K, cyc);
                end else begin
                    e = q[K].pop_front();
                    chk($sformatf("rv_cycle dut%0d", K), cyc, e.cyc);
                    chk($sformatf("rv_err dut%0d", K), err[K], e.err);
                    chk($sformatf("rv_rdata dut%0d", K), rdata[K], e.data);
                end
            end
        end
    end

    // Drives one request, waits for gnt, checks SRAM strobe, queues expectation
    task automatic fetch(input int k, input logic [31:0] a, input logic e,
                         input logic [9:0] w, input int ew);
        int   n = 0;
        exp_t x;
        req[k]  = 1'b1;
        addr[k] = a;
        #1;
        while (!gnt[k] && n < 20) begin
            chk($sformatf("idle_mem_en dut%0d", k), en[k], '0);
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("gnt_wait dut%0d a=%h", k, a), n, ew);
        if (gnt[k]) begin
            chk($sformatf("mem_en dut%0d a=%h", k, a), en[k], !e);
            if (!e) chk($sformatf("mem_addr dut%0d a=%h", k, a), maddr[k], w);
            x.cyc  = cyc + LAT[k];
            x.err  = e;
            x.data = e ? 32'h0 : mdl(w);
            q[k].push_back(x);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) addr[i] = '0;
        req[0]  = 1'b1;
        addr[0] = 32'h10;
        #12;
        chk("rst_gnt", gnt, '0);
        chk("rst_rvalid", rvalid, '0);
        chk("rst_mem_en", en, '0);
        chk("rst_err", err, '0);
        chk("rst_rdata0", rdata[0], '0);
        chk("rst_rdata1", rdata[1], '0);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fetch(0, 32'h10, 1'b0, 10'd4, 0);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        fetch(0, 32'h0, 1'b0, 10'd0, 0);
        fetch(0, 32'h4, 1'b0, 10'd1, 0);
        fetch(0, 32'h8, 1'b0, 10'd2, 0);
        fetch(0, 32'hC, 1'b0, 10'd3, 0);
        fetch(0, 32'h1000, 1'b1, 10'd0, 0);
        fetch(0, 32'h0FFC, 1'b0, 10'h3FF, 0);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        fetch(1, 32'h0, 1'b0, 10'd0, 0);
        fetch(1, 32'h4, 1'b0, 10'd1, 0);
        fetch(1, 32'h8, 1'b0, 10'd2, 1);
        fetch(1, 32'hC, 1'b0, 10'd3, 0);
        req[1] = 1'b0;
        repeat (5) @(negedge clk);

        fetch(2, 32'h10, 1'b0, 10'd4, 2);
        req[2] = 1'b0;
        @(negedge clk);
        req[2]  = 1'b1;
        addr[2] = 32'h20;
        #1;
        chk("ws_early_gnt", gnt[2], '0);
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        fetch(2, 32'h20, 1'b0, 10'd8, 2);
        req[2] = 1'b0;
        repeat (2) @(negedge clk);

        fetch(3, 32'hFFFF_FFFC, 1'b0, 10'h3FF, 0);
        fetch(3, 32'hFFFF_F000, 1'b0, 10'd0, 0);
        fetch(3, 32'hFFFF_EFFC, 1'b1, 10'd0, 0);
        req[3] = 1'b0;
        repeat (5) @(negedge clk);

        fetch(1, 32'h10, 1'b0, 10'd4, 0);
        fetch(1, 32'h14, 1'b0, 10'd5, 0);
        req[1] = 1'b0;
        rst_n  = 1'b0;
        #2;
        chk("mid_rst_rvalid", rvalid[1], '0);
        chk("mid_rst_rdata", rdata[1], '0);
        chk("mid_rst_err", err[1], '0);
        chk("mid_rst_mem_en", en[1], '0);
        q[1].delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        fetch(1, 32'h10, 1'b0, 10'd4, 0);
        req[1] = 1'b0;
        repeat (6) @(negedge clk);

        for (int k = 0; k < N; k++) begin
            chk($sformatf("drained dut%0d", k), q[k].size(), '0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
